// File: rtl/miner_pkg.sv
// Shared miner back-end definitions: comparator state encoding and default widths.
package miner_pkg;

  localparam int unsigned DEF_W  = 32;
  localparam int unsigned DEF_N  = 8;
  localparam int unsigned HASH_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/sub_word.sv
// One word of the ripple borrow chain: d = a + ~b + cin, cout is the carry (no-borrow) out.
module sub_word #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] d,
  output logic         cout
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
  assign d     = w_sum[W-1:0];
  assign cout  = w_sum[W];

endmodule

// File: rtl/target_cmp_256.sv
// Sequential hash-vs-target comparator: subtracts one word per cycle, LSW first,
// reporting less/equal and the full modular difference.
module target_cmp_256
  import miner_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned N = DEF_N
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] hash,
  input  logic [W*N-1:0] target,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           less,
  output logic           equal,
  output logic [W*N-1:0] diff
);

  localparam int unsigned OW    = W * N;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  cmp_state_t r_state, w_state_nxt;

  logic [OW-1:0]   r_h, r_t;
  logic [OW-W-1:0] r_acc;
  logic [OW-1:0]   r_diff;
  logic [IDX_W-1:0] r_idx;
  logic            r_carry, r_zero;
  logic            r_less, r_equal;
  logic            r_in_ready, r_out_valid;
  logic            w_accept, w_last;
  logic [W-1:0]    w_d;
  logic            w_cout;

  // Single subtractor slice, time-shared: operands shift down one word per cycle.
  sub_word #(.W(W)) u_sub_word (
    .a    (r_h[W-1:0]),
    .b    (r_t[W-1:0]),
    .cin  (r_carry),
    .d    (w_d),
    .cout (w_cout)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SUB;
        end
      end
      SUB: begin
        if (r_idx == IDX_W'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Working registers feed a separate result register so results hold until the next DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_h         <= '0;
      r_t         <= '0;
      r_acc       <= '0;
      r_diff      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b1;
      r_zero      <= 1'b1;
      r_less      <= 1'b0;
      r_equal     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_h     <= hash;
        r_t     <= target;
        r_idx   <= '0;
        r_carry <= 1'b1;
        r_zero  <= 1'b1;
      end else if (r_state == SUB) begin
        r_h     <= r_h >> W;
        r_t     <= r_t >> W;
        r_acc   <= {w_d, r_acc[OW-W-1:W]};
        r_carry <= w_cout;
        r_zero  <= r_zero && (w_d == '0);
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_diff  <= {w_d, r_acc};
          r_less  <= ~w_cout;
          r_equal <= r_zero && (w_d == '0);
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign less      = r_less;
  assign equal     = r_equal;
  assign diff      = r_diff;

endmodule

// File: tb/tb_target_cmp_256.sv
// Bench for target_cmp_256: directed and random compares against a plain-arithmetic model.
module tb_target_cmp_256;

  logic         clock = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] hash;
  logic [255:0] target;
  logic         out_valid;
  logic         out_ready;
  logic         less;
  logic         equal;
  logic [255:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  target_cmp_256 dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hash      (hash),
    .target    (target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .less      (less),
    .equal     (equal),
    .diff      (diff)
  );

  always #5 clock = ~clock;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: unsigned 256-bit compare and modular difference.
  function automatic logic [257:0] ref_cmp(input logic [255:0] h, input logic [255:0] t);
    logic [255:0] d;
    d = h - t;
    return {(h < t), (h == t), d};
  endfunction

  // Drives one operand pair, waits (bounded) for the result, samples it, then handshakes.
  task automatic run_op(input logic [255:0] h, input logic [255:0] t, input bit early,
                        output int cyc, output logic l, output logic e, output logic [255:0] d);
    @(negedge clock);
    hash = h; target = t; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; hash = rand256(); target = rand256();
    if (early) out_ready = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    l = less; e = equal; d = diff;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hash = '0; target = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (less !== 1'b0 || equal !== 1'b0) begin n_errors++; $display("FAIL reset_flags less=%b equal=%b exp=0,0", less, equal); end
    n_checks++; if (diff !== 256'd0) begin n_errors++; $display("FAIL reset_diff got=%h exp=0", diff); end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [255:0] hv [6];
    logic [255:0] tv [6];
    logic [257:0] exp;
    logic [255:0] d;
    logic l, e;
    int cyc;
    hv[0] = 256'd5;  tv[0] = 256'd3;
    hv[1] = 256'd3;  tv[1] = 256'd5;
    hv[2] = {32'd0, {224{1'b1}}}; tv[2] = {32'd0, {224{1'b1}}};
    hv[3] = 256'd1 << 32;        tv[3] = 256'd1;
    hv[4] = 256'd0;  tv[4] = 256'd0;
    hv[5] = 256'd7;  tv[5] = {256{1'b1}};
    for (int i = 0; i < 6; i++) begin
      run_op(hv[i], tv[i], 1'b0, cyc, l, e, d);
      exp = ref_cmp(hv[i], tv[i]);
      n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL dir%0d_latency got=%0d exp=8", i, cyc); end
      n_checks++; if (l !== exp[257] || e !== exp[256]) begin n_errors++; $display("FAIL dir%0d_flags less=%b equal=%b exp=%b,%b", i, l, e, exp[257], exp[256]); end
      n_checks++; if (d !== exp[255:0]) begin n_errors++; $display("FAIL dir%0d_diff got=%h exp=%h", i, d, exp[255:0]); end
    end
    // Spot-check the documented literal results independently of the model.
    run_op(256'd3, 256'd5, 1'b0, cyc, l, e, d);
    n_checks++; if (d !== {{224{1'b1}}, 32'hFFFF_FFFE} || l !== 1'b1) begin n_errors++; $display("FAIL dir_lit_3m5 diff=%h less=%b", d, l); end
    run_op(256'd1 << 32, 256'd1, 1'b0, cyc, l, e, d);
    n_checks++; if (d[63:0] !== 64'h0000_0000_FFFF_FFFF || l !== 1'b0 || e !== 1'b0) begin n_errors++; $display("FAIL dir_lit_xword diff=%h less=%b equal=%b", d[63:0], l, e); end
  endtask

  task automatic test_random();
    logic [255:0] h, t, d;
    logic [257:0] exp;
    logic l, e;
    int cyc, bad, wi;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      h = rand256(); t = rand256();
      case ($urandom_range(0, 3))
        0: t = h;
        1: begin t = h; wi = $urandom_range(0, 7); t[wi*32 +: 32] = $urandom; end
        2: begin h = {256{1'b1}} >> $urandom_range(0, 255); t = h + 256'd1; end
        default: ;
      endcase
      run_op(h, t, i[0], cyc, l, e, d);
      exp = ref_cmp(h, t);
      n_checks++;
      if (cyc !== 8 || l !== exp[257] || e !== exp[256] || d !== exp[255:0]) begin
        n_errors++; bad++;
        $display("FAIL rand%0d cyc=%0d less=%b equal=%b diff=%h exp less=%b equal=%b diff=%h",
                 i, cyc, l, e, d, exp[257], exp[256], exp[255:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] h1, t1, h2, t2, d;
    logic [257:0] exp;
    logic l, e;
    int cyc;
    h1 = rand256(); t1 = rand256(); h2 = rand256(); t2 = h2 + 256'd1;
    exp = ref_cmp(h1, t1);
    @(negedge clock);
    hash = h1; target = t1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin @(posedge clock); #1; cyc++; end
    n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL bp_latency got=%0d exp=8", cyc); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; hash = rand256(); target = rand256();
      @(posedge clock); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || less !== exp[257] || equal !== exp[256] || diff !== exp[255:0]) begin
        n_errors++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b less=%b equal=%b diff=%h exp 1,0,%b,%b,%h",
                 k, out_valid, in_ready, less, equal, diff, exp[257], exp[256], exp[255:0]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0,1", out_valid, in_ready); end
    n_checks++; if (diff !== exp[255:0] || less !== exp[257]) begin n_errors++; $display("FAIL bp_keep diff=%h exp=%h", diff, exp[255:0]); end
    run_op(h2, t2, 1'b0, cyc, l, e, d);
    exp = ref_cmp(h2, t2);
    n_checks++;
    if (cyc !== 8 || l !== exp[257] || e !== exp[256] || d !== exp[255:0]) begin
      n_errors++; $display("FAIL bp_second cyc=%0d less=%b equal=%b diff=%h exp diff=%h", cyc, l, e, d, exp[255:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    logic l, e;
    int cyc, pulses;
    @(negedge clock);
    hash = rand256(); target = rand256(); in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_state out_valid=%b in_ready=%b exp 0,1", out_valid, in_ready); end
    @(negedge clock); resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
    run_op(256'd1, 256'd2, 1'b0, cyc, l, e, d);
    n_checks++; if (cyc !== 8 || l !== 1'b1 || e !== 1'b0 || d !== {256{1'b1}}) begin n_errors++; $display("FAIL midrst_after cyc=%0d less=%b equal=%b diff=%h", cyc, l, e, d); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
